// File: rtl/wb_unit.sv
// wb_unit: register-file writeback unit.
// This block is the only writer of the register-file write port. It merges
// single-cycle ALU results with in-order load responses from the data-memory
// bus. It extracts bytes and halfwords from load words and sign- or
// zero-extends them. It also publishes which registers still wait on a queued
// load, so that decode can stall on RAW hazards.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   alu_valid/ready       ALU result handshake (alu_dest, alu_result)
//   ld_issue_valid/ready  load-issue handshake (ld_dest, ld_type, ld_byte_off)
//   mem_readdatavalid     load response strobe, cannot be stalled (mem_readdata)
//   rf_write/_addr/rf_data  registered register-file write port
//   busy_mask             bit i set while a queued load targets register i
//   resp_err              sticky: a response arrived with no load queued
//   idle                  nothing queued, nothing held, no write this cycle
module wb_unit #(
    parameter int LQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_dest,
    input  logic [31:0] alu_result,
    input  logic        ld_issue_valid,
    output logic        ld_issue_ready,
    input  logic [4:0]  ld_dest,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  ld_byte_off,
    input  logic        mem_readdatavalid,
    input  logic [31:0] mem_readdata,
    output logic        rf_write,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_data,
    output logic [31:0] busy_mask,
    output logic        resp_err,
    output logic        idle
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LQ_DEPTH);

    typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

    logic [4:0]       q_dest [LQ_DEPTH];
    logic [2:0]       q_type [LQ_DEPTH];
    logic [1:0]       q_off  [LQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    state_t      state, state_nxt;
    logic [4:0]  hold_dest;
    logic [31:0] hold_data;
    logic        hold_capture;

    logic        push, pop, alu_acc;
    logic [7:0]  lane8;
    logic [15:0] half16;
    logic [31:0] ld_data;
    logic        sel_valid;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic [31:0] busy_raw;
    logic [PTR_W-1:0] busy_idx;

    // A full queue refuses issues even if a response frees a slot this cycle.
    assign ld_issue_ready = (count < DEPTH_C);
    assign push           = ld_issue_valid && ld_issue_ready;
    assign pop            = mem_readdatavalid && (count != '0);
    assign alu_acc        = alu_valid && alu_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            q_dest[wr_ptr] <= ld_dest;
            q_type[wr_ptr] <= ld_type;
            q_off[wr_ptr]  <= ld_byte_off;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Lane and halfword selection for the entry at the head of the queue.
    always_comb begin
        case (q_off[rd_ptr])
            2'd0:    lane8 = mem_readdata[7:0];
            2'd1:    lane8 = mem_readdata[15:8];
            2'd2:    lane8 = mem_readdata[23:16];
            default: lane8 = mem_readdata[31:24];
        endcase
        half16 = q_off[rd_ptr][1] ? mem_readdata[31:16] : mem_readdata[15:0];
        case (q_type[rd_ptr])
            3'd0:    ld_data = {{24{lane8[7]}}, lane8};
            3'd1:    ld_data = {24'h0, lane8};
            3'd2:    ld_data = {{16{half16[15]}}, half16};
            3'd3:    ld_data = {16'h0, half16};
            default: ld_data = mem_readdata;
        endcase
    end

    // Holding register FSM: state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Holding register FSM: next state. A load response always wins the write
    // port, so an ALU result that collides with one is parked until a cycle
    // without a response.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (alu_valid && pop) state_nxt = ST_HOLD;
            ST_HOLD:  if (!pop)             state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Holding register FSM: outputs.
    always_comb begin
        alu_ready    = (state == ST_EMPTY);
        hold_capture = (state == ST_EMPTY) && alu_valid && pop;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_dest <= '0;
            hold_data <= '0;
        end else if (hold_capture) begin
            hold_dest <= alu_dest;
            hold_data <= alu_result;
        end
    end

    // Write source priority: load response, then held ALU, then fresh ALU.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = alu_dest;
        sel_data  = alu_result;
        if (pop) begin
            sel_valid = 1'b1;
            sel_addr  = q_dest[rd_ptr];
            sel_data  = ld_data;
        end else if (state == ST_HOLD) begin
            sel_valid = 1'b1;
            sel_addr  = hold_dest;
            sel_data  = hold_data;
        end else if (alu_acc) begin
            sel_valid = 1'b1;
        end
    end

    // Writes to $zero are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_write      <= 1'b0;
            rf_write_addr <= '0;
            rf_data       <= '0;
        end else begin
            rf_write <= sel_valid && (sel_addr != 5'd0);
            if (sel_valid && (sel_addr != 5'd0)) begin
                rf_write_addr <= sel_addr;
                rf_data       <= sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)                                 resp_err <= 1'b0;
        else if (mem_readdatavalid && count == '0)  resp_err <= 1'b1;
    end

    // Walk the occupied slots from the head; the slot offset from rd_ptr is
    // compared with count so that stale entries never contribute.
    always_comb begin
        busy_raw = '0;
        busy_idx = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            busy_idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) busy_raw[q_dest[busy_idx]] = 1'b1;
        end
    end

    assign busy_mask = busy_raw & ~32'h1;
    assign idle      = (count == '0) && (state == ST_EMPTY) && !rf_write;

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: self-checking bench for wb_unit.
// A small model tracks the load queue and the ALU holding register. It pushes
// every expected register-file write to a scoreboard when stimulus is driven,
// and a negedge monitor pops and compares each write the DUT produces.
module tb_wb_unit;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dest;
    logic [31:0] alu_result;
    logic        ld_issue_valid;
    logic        ld_issue_ready;
    logic [4:0]  ld_dest;
    logic [2:0]  ld_type;
    logic [1:0]  ld_byte_off;
    logic        mem_readdatavalid;
    logic [31:0] mem_readdata;
    logic        rf_write;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_data;
    logic [31:0] busy_mask;
    logic        resp_err;
    logic        idle;

    typedef struct {
        logic [4:0] dest;
        logic [2:0] typ;
        logic [1:0] off;
    } ld_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    ld_t mq[$];
    wr_t sb[$];
    bit  mhold;
    wr_t mhold_w;
    bit  exp_err;
    int  n_cmp;
    int  n_err;

    wb_unit #(.LQ_DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .alu_valid         (alu_valid),
        .alu_ready         (alu_ready),
        .alu_dest          (alu_dest),
        .alu_result        (alu_result),
        .ld_issue_valid    (ld_issue_valid),
        .ld_issue_ready    (ld_issue_ready),
        .ld_dest           (ld_dest),
        .ld_type           (ld_type),
        .ld_byte_off       (ld_byte_off),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_readdata      (mem_readdata),
        .rf_write          (rf_write),
        .rf_write_addr     (rf_write_addr),
        .rf_data           (rf_data),
        .busy_mask         (busy_mask),
        .resp_err          (resp_err),
        .idle              (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference load formatting written from the data-format description.
    function automatic logic [31:0] fmt(input logic [2:0] t, input logic [1:0] o,
                                        input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*o +: 8];
        h = o[1] ? w[31:16] : w[15:0];
        case (t)
            3'd0:    return 32'($signed(b));
            3'd1:    return {24'h0, b};
            3'd2:    return 32'($signed(h));
            3'd3:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Every write the DUT commits must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t w;
        if (rf_write === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %h, expected no write",
                         rf_write_addr, rf_data);
            end else begin
                w = sb.pop_front();
                if (rf_write_addr !== w.addr || rf_data !== w.data) begin
                    n_err++;
                    $display("[TB] FAIL write_order: got addr %0d data %h, expected addr %0d data %h",
                             rf_write_addr, rf_data, w.addr, w.data);
                end
            end
        end
    end

    task automatic clear_inputs();
        alu_valid = 0; alu_dest = 0; alu_result = 0;
        ld_issue_valid = 0; ld_dest = 0; ld_type = 0; ld_byte_off = 0;
        mem_readdatavalid = 0; mem_readdata = 0;
    endtask

    // Drive one cycle of stimulus, update the model, advance past the edge.
    task automatic cycle(input bit av, input logic [4:0] ad, input logic [31:0] ar,
                         input bit lv, input logic [4:0] ldd, input logic [2:0] lt,
                         input logic [1:0] lo, input bit rv, input logic [31:0] rw);
        bit  ready_pre;
        bit  popped;
        ld_t e;
        wr_t w;
        alu_valid = av; alu_dest = ad; alu_result = ar;
        ld_issue_valid = lv; ld_dest = ldd; ld_type = lt; ld_byte_off = lo;
        mem_readdatavalid = rv; mem_readdata = rw;
        ready_pre = (mq.size() < 4);
        popped    = rv && (mq.size() > 0);
        if (rv && mq.size() == 0) exp_err = 1;
        if (popped) begin
            e = mq.pop_front();
            if (e.dest != 0) begin
                w.addr = e.dest;
                w.data = fmt(e.typ, e.off, rw);
                sb.push_back(w);
            end
        end
        if (mhold) begin
            if (!popped) begin
                if (mhold_w.addr != 0) sb.push_back(mhold_w);
                mhold = 0;
            end
        end else if (av) begin
            w.addr = ad;
            w.data = ar;
            if (popped) begin
                mhold   = 1;
                mhold_w = w;
            end else if (ad != 0) begin
                sb.push_back(w);
            end
        end
        if (lv && ready_pre) begin
            e.dest = ldd; e.typ = lt; e.off = lo;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        reset = 0;
        clear_inputs();
        mq.delete();
        mhold   = 0;
        exp_err = 0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic test_reset();
        do_reset(2);
        n_cmp++;
        if (rf_write !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rf_write: got %b expected 0", rf_write); end
        n_cmp++;
        if (busy_mask !== 32'h0) begin n_err++; $display("[TB] FAIL reset_busy: got %h expected 0", busy_mask); end
        n_cmp++;
        if (alu_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_alu_ready: got %b expected 1", alu_ready); end
        n_cmp++;
        if (ld_issue_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ld_ready: got %b expected 1", ld_issue_ready); end
        n_cmp++;
        if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL reset_idle: got %b expected 1", idle); end
        n_cmp++;
        if (resp_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_resp_err: got %b expected 0", resp_err); end
        n_cmp++;
        if (rf_write_addr !== 5'd0 || rf_data !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL reset_rf_port: got addr %0d data %h expected 0/0", rf_write_addr, rf_data);
        end
    endtask

    task automatic test_alu();
        cycle(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (rf_write !== 1'b1 || rf_write_addr !== 5'd3 || rf_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("[TB] FAIL alu_write: got %b/%0d/%h expected 1/3/deadbeef", rf_write, rf_write_addr, rf_data);
        end
        cycle(1, 5'd0, 32'h12345678, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (rf_write !== 1'b0) begin n_err++; $display("[TB] FAIL alu_dest0: got rf_write %b expected 0", rf_write); end
        nop(1);
        n_cmp++;
        if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL alu_idle: got %b expected 1", idle); end
    endtask

    task automatic test_loads();
        logic [4:0]  dst [7] = '{5'd5, 5'd6, 5'd10, 5'd13, 5'd14, 5'd15, 5'd16};
        logic [2:0]  typ [7] = '{3'd0, 3'd3, 3'd4, 3'd2, 3'd1, 3'd0, 3'd7};
        logic [1:0]  off [7] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1};
        logic [31:0] wrd [7] = '{32'h12803456, 32'h12803456, 32'h12803456, 32'h00008001,
                                 32'hF0123456, 32'h12347F00, 32'hCAFEF00D};
        logic [31:0] exp [7] = '{32'hFFFFFF80, 32'h00001280, 32'h12803456, 32'hFFFF8001,
                                 32'h000000F0, 32'h0000007F, 32'hCAFEF00D};
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, 0, 1, dst[i], typ[i], off[i], 0, 0);
            n_cmp++;
            if (busy_mask !== (32'h1 << dst[i])) begin
                n_err++;
                $display("[TB] FAIL load_busy_set[%0d]: got %h expected %h", i, busy_mask, 32'h1 << dst[i]);
            end
            cycle(0, 0, 0, 0, 0, 0, 0, 1, wrd[i]);
            n_cmp++;
            if (rf_write !== 1'b1 || rf_write_addr !== dst[i] || rf_data !== exp[i]) begin
                n_err++;
                $display("[TB] FAIL load_data[%0d]: got %b/%0d/%h expected 1/%0d/%h",
                         i, rf_write, rf_write_addr, rf_data, dst[i], exp[i]);
            end
            n_cmp++;
            if (busy_mask !== 32'h0) begin
                n_err++;
                $display("[TB] FAIL load_busy_clear[%0d]: got %h expected 0", i, busy_mask);
            end
        end
    endtask

    task automatic test_collision();
        cycle(0, 0, 0, 1, 5'd7, 3'd4, 2'd0, 0, 0);
        n_cmp++;
        if (alu_ready !== 1'b1) begin n_err++; $display("[TB] FAIL coll_ready_pre: got %b expected 1", alu_ready); end
        cycle(1, 5'd8, 32'h22222222, 0, 0, 0, 0, 1, 32'h11111111);
        n_cmp++;
        if (rf_write !== 1'b1 || rf_write_addr !== 5'd7 || rf_data !== 32'h11111111) begin
            n_err++;
            $display("[TB] FAIL coll_first: got %b/%0d/%h expected 1/7/11111111", rf_write, rf_write_addr, rf_data);
        end
        n_cmp++;
        if (alu_ready !== 1'b0) begin n_err++; $display("[TB] FAIL coll_ready_hold: got %b expected 0", alu_ready); end
        nop(1);
        n_cmp++;
        if (rf_write !== 1'b1 || rf_write_addr !== 5'd8 || rf_data !== 32'h22222222) begin
            n_err++;
            $display("[TB] FAIL coll_second: got %b/%0d/%h expected 1/8/22222222", rf_write, rf_write_addr, rf_data);
        end
        n_cmp++;
        if (alu_ready !== 1'b1) begin n_err++; $display("[TB] FAIL coll_ready_after: got %b expected 1", alu_ready); end
        nop(1);
    endtask

    task automatic test_full_wrap();
        for (int d = 1; d <= 4; d++) cycle(0, 0, 0, 1, 5'(d), 3'd4, 2'd0, 0, 0);
        n_cmp++;
        if (ld_issue_ready !== 1'b0) begin n_err++; $display("[TB] FAIL full_ready: got %b expected 0", ld_issue_ready); end
        n_cmp++;
        if (busy_mask !== 32'h0000001E) begin n_err++; $display("[TB] FAIL full_busy: got %h expected 0000001e", busy_mask); end
        // Issue offered while full, alongside a response: must not be taken.
        cycle(0, 0, 0, 1, 5'd20, 3'd4, 2'd0, 1, 32'hA0000001);
        n_cmp++;
        if (ld_issue_ready !== 1'b1) begin n_err++; $display("[TB] FAIL full_ready_after_pop: got %b expected 1", ld_issue_ready); end
        n_cmp++;
        if (busy_mask !== 32'h0000001C) begin n_err++; $display("[TB] FAIL full_no_bypass: got %h expected 0000001c", busy_mask); end
        cycle(0, 0, 0, 1, 5'd9, 3'd4, 2'd0, 0, 0);
        n_cmp++;
        if (busy_mask !== 32'h0000021C) begin n_err++; $display("[TB] FAIL wrap_busy: got %h expected 0000021c", busy_mask); end
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'hA0000002);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'hA0000003);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'hA0000004);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'hA0000009);
        n_cmp++;
        if (rf_write_addr !== 5'd9 || rf_data !== 32'hA0000009) begin
            n_err++;
            $display("[TB] FAIL wrap_last: got %0d/%h expected 9/a0000009", rf_write_addr, rf_data);
        end
        nop(1);
        n_cmp++;
        if (busy_mask !== 32'h0 || ld_issue_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL wrap_drained: got busy %h ready %b expected 0/1", busy_mask, ld_issue_ready);
        end
    endtask

    task automatic test_error();
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h55555555);
        n_cmp++;
        if (rf_write !== 1'b0) begin n_err++; $display("[TB] FAIL err_no_write: got %b expected 0", rf_write); end
        n_cmp++;
        if (resp_err !== 1'b1) begin n_err++; $display("[TB] FAIL err_set: got %b expected 1", resp_err); end
        nop(3);
        n_cmp++;
        if (resp_err !== 1'b1) begin n_err++; $display("[TB] FAIL err_sticky: got %b expected 1", resp_err); end
    endtask

    task automatic test_reset_midop();
        do_reset(1);
        cycle(0, 0, 0, 1, 5'd11, 3'd4, 2'd0, 0, 0);
        cycle(0, 0, 0, 1, 5'd12, 3'd4, 2'd0, 0, 0);
        n_cmp++;
        if (busy_mask !== 32'h00001800) begin n_err++; $display("[TB] FAIL midop_busy: got %h expected 00001800", busy_mask); end
        do_reset(1);
        n_cmp++;
        if (busy_mask !== 32'h0 || idle !== 1'b1 || resp_err !== 1'b0 || ld_issue_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL midop_cleared: got busy %h idle %b err %b ready %b expected 0/1/0/1",
                     busy_mask, idle, resp_err, ld_issue_ready);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h77777777);
        n_cmp++;
        if (resp_err !== 1'b1 || rf_write !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midop_stale_resp: got err %b write %b expected 1/0", resp_err, rf_write);
        end
        nop(2);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        mhold   = 0;
        exp_err = 0;
        reset   = 0;
        clear_inputs();
        test_reset();
        test_alu();
        test_loads();
        test_collision();
        test_full_wrap();
        test_error();
        test_reset_midop();
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size()); end
        n_cmp++;
        if (resp_err !== exp_err) begin n_err++; $display("[TB] FAIL final_resp_err: got %b expected %b", resp_err, exp_err); end
        n_cmp++;
        if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL final_idle: got %b expected 1", idle); end
        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
Register-file writeback unit. It is the single writer for the register file's write port (write, write_addr, data_in). It merges single-cycle ALU results with in-order load responses from the data-memory bus. It performs load byte/halfword extraction and sign/zero extension. It tracks pending load destinations so the decode stage can stall on RAW hazards.

Parameters:
LQ_DEPTH, 4, pending-load queue entries (power of 2, >=2)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-low (0 = reset, sampled on posedge clk)
alu_valid  input  1  ALU result offered this cycle
alu_ready  output  1  ALU result accepted when alu_valid && alu_ready
alu_dest  input  5  ALU destination register
alu_result  input  32  ALU result
ld_issue_valid  input  1  load issued to memory this cycle
ld_issue_ready  output  1  queue can accept a load issue
ld_dest  input  5  load destination register
ld_type  input  3  0=LB 1=LBU 2=LH 3=LHU 4=LW; 5-7 treated as LW
ld_byte_off  input  2  address[1:0] of the load
mem_readdatavalid  input  1  load response present (cannot be stalled)
mem_readdata  input  32  raw response word
rf_write  output  1  register-file write enable
rf_write_addr  output  5  register-file write address
rf_data  output  32  register-file write data
busy_mask  output  32  bit i = 1 if some queued load targets register i (bit 0 always 0)
resp_err  output  1  sticky: response arrived with the queue empty
idle  output  1  queue empty, holding register empty, no write this cycle

Behaviour:
- Reset (reset==0 at posedge):
  - Clears queue pointers/count, holding register, rf_write, rf_write_addr, rf_data, resp_err.
  - Outputs after reset: rf_write=0, rf_write_addr=0, rf_data=0, busy_mask=0, alu_ready=1, ld_issue_ready=1, idle=1, resp_err=0.
  - Reset mid-operation discards queued loads and any held ALU result; responses for those loads then set resp_err.
- Load queue:
  - FIFO of {dest, type, byte_off}, LQ_DEPTH entries.
  - Push on ld_issue_valid && ld_issue_ready. ld_issue_ready = (count < LQ_DEPTH), with no pop bypass.
  - Pop on mem_readdatavalid when count>0. Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo LQ_DEPTH.
- Response with count==0: no write, no pop, resp_err set to 1 until reset.
- Load data formatting (little-endian lane k = bits[8k+7:8k]):
  - LB/LBU: lane = byte_off; sign/zero extend 8->32.
  - LH/LHU: halfword = byte_off[1] ? bits[31:16] : bits[15:0]; sign/zero extend 16->32. byte_off[0] is ignored; misalignment is trapped upstream.
  - LW: word as-is; byte_off is ignored.
- Write arbitration, one write per cycle, all rf_* outputs registered:
  - Priority 1: load response (pop). rf_* at the next edge = {1, dest, formatted data}.
  - Priority 2: held ALU result, if the holding register is full.
  - Priority 3: incoming ALU result (alu_valid && alu_ready), bypassing the holding register.
- Holding register FSM:
  - EMPTY: alu_ready=1.
    - Accepted ALU result and no load response -> written next edge, stay EMPTY.
    - Accepted ALU result with a simultaneous load response -> captured, go HOLD.
  - HOLD: alu_ready=0.
    - No load response -> write held result, go EMPTY.
    - Load response present -> remain HOLD.
- Latency: an accepted input appears on rf_* at the next posedge, or later if deferred by HOLD. rf_write drops to 0 in cycles with nothing to write; rf_write_addr/rf_data hold their last values.
- Destination 0: the entry/result is consumed normally but rf_write is forced to 0. $zero is never written.
- busy_mask:
  - Combinational OR of one-hot(dest) over valid queue entries, with bit 0 masked.
  - Set the cycle after push; cleared the cycle after the last matching entry pops.
  - A register with two queued loads stays busy until the second one pops.
- Ordering: writes commit in arrival order; there is no WAW reordering. The decode stage stalls on busy_mask.
- idle = (count==0) && (state==EMPTY) && !rf_write.

Test Plan:
- Reset (reset=0 for 2 cycles, then 1) -> rf_write=0, busy_mask=0, alu_ready=1, ld_issue_ready=1, idle=1, resp_err=0.
- ALU: alu_dest=3, alu_result=0xDEADBEEF for one cycle -> next cycle rf_write=1, rf_write_addr=3, rf_data=0xDEADBEEF; alu_dest=0 -> rf_write stays 0.
- Loads:
  - Issue LB dest=5 off=2; response 0x1280_3456 -> rf_data=0xFFFFFF80, busy_mask[5] 1 then 0.
  - LHU off=2, same word -> 0x00001280.
  - LW -> 0x12803456.
- Collision:
  - Response (dest=7, LW 0x11111111) coincides with ALU (dest=8, 0x22222222).
  - Expected: cycle+1 writes r7; cycle+2 writes r8; alu_ready=0 for exactly one cycle.
- Full/wrap:
  - Issue 4 loads (dest 1-4) -> ld_issue_ready=0.
  - One response -> ready=1; issue dest=9 -> entry wraps.
  - 4 responses -> writes r2, r3, r4, r9 in order; busy_mask=0.
- Error/reset mid-op:
  - Response with empty queue -> resp_err=1 sticky, no write.
  - Reset with 2 loads queued -> busy_mask=0, count=0, and the later response sets resp_err.
